// File: rtl/arm_pkg.sv
// Purpose: shared LDM/STM field positions and sequencer state encoding.
// Latency: none (declarations only).
// Backpressure: not applicable.
package arm_pkg;

    // Bit positions inside an ARMv4 block data transfer word
    localparam int BIT_P  = 24;
    localparam int BIT_U  = 23;
    localparam int BIT_W  = 21;
    localparam int BIT_L  = 20;
    localparam int RN_HI  = 19;
    localparam int RN_LO  = 16;
    localparam int LIST_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_XFER = 3'd2,
        ST_WB   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/block_xfer_seq_if.sv
// Purpose: memory-side bus of the block transfer sequencer.
// Latency: none (wires only).
// Backpressure: mem_ready from the slave stalls the master's current access.
interface block_xfer_seq_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/reg_list_scan.sv
// Purpose: population count and lowest set index of a 16-bit register list.
// Latency: combinational.
// Backpressure: none.
module reg_list_scan
    import arm_pkg::*;
(
    input  logic [LIST_W-1:0] list_i,
    output logic [4:0]        count_o,
    output logic [3:0]        low_idx_o
);

    // Count set bits; walk downwards so the last hit is the lowest index
    always_comb begin
        count_o   = 5'd0;
        low_idx_o = 4'd0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            count_o = count_o + {4'd0, list_i[i]};
            if (list_i[i]) begin
                low_idx_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/block_xfer_seq.sv
// Purpose: sequences one LDM/STM instruction into per-register memory accesses and bank writes.
// Latency: start -> CALC (1) -> one XFER per register (+stall cycles) -> optional WB (1) -> DONE pulse.
// Backpressure: mem_ready=0 holds the current access; start is ignored while not IDLE.
module block_xfer_seq
    import arm_pkg::*;
#(
    parameter int BASE_WB_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [31:0]              instr,
    input  logic [31:0]              base_data,
    input  logic [31:0]              store_data,
    output logic                     busy,
    output logic                     done,
    output logic [3:0]               reg_addr,
    output logic                     latch_reg,
    output logic [31:0]              wb_data,
    block_xfer_seq_if.master         mem
);

    state_t      state_q, state_d;
    logic [15:0] list_q;
    logic        load_q, p_q, u_q, w_q;
    logic [3:0]  rn_q;
    logic [31:0] base_q;
    logic [31:0] addr_q;
    logic [31:0] wb_val_q;
    logic        wb_do_q;

    logic [4:0]  scan_cnt;
    logic [3:0]  scan_idx;
    logic [31:0] four_n;
    logic [31:0] start_addr;
    logic [31:0] wb_val_calc;
    logic        wb_do_calc;

    // P/U/W/L are the only control bits this block acts on
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31:25], instr[22]};

    // The remaining list drives the scan: full list in CALC, shrinking during XFER
    reg_list_scan u_scan (
        .list_i    (list_q),
        .count_o   (scan_cnt),
        .low_idx_o (scan_idx)
    );

    // Addressing-mode arithmetic, evaluated during CALC from the captured instruction
    always_comb begin
        four_n = {25'd0, scan_cnt, 2'b00};
        case ({p_q, u_q})
            2'b01:   start_addr = base_q;
            2'b11:   start_addr = base_q + 32'd4;
            2'b00:   start_addr = base_q - four_n + 32'd4;
            default: start_addr = base_q - four_n;
        endcase
        wb_val_calc = u_q ? (base_q + four_n) : (base_q - four_n);
        // A load that includes the base keeps the loaded value instead of the update
        wb_do_calc  = (BASE_WB_EN != 0) && w_q && !(load_q && list_q[rn_q]);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction capture, address/writeback setup and list advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            list_q   <= 16'd0;
            load_q   <= 1'b0;
            p_q      <= 1'b0;
            u_q      <= 1'b0;
            w_q      <= 1'b0;
            rn_q     <= 4'd0;
            base_q   <= 32'd0;
            addr_q   <= 32'd0;
            wb_val_q <= 32'd0;
            wb_do_q  <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                list_q <= instr[LIST_W-1:0];
                load_q <= instr[BIT_L];
                p_q    <= instr[BIT_P];
                u_q    <= instr[BIT_U];
                w_q    <= instr[BIT_W];
                rn_q   <= instr[RN_HI:RN_LO];
                base_q <= base_data;
            end
            if (state_q == ST_CALC) begin
                addr_q   <= start_addr & 32'hFFFF_FFFC;
                wb_val_q <= wb_val_calc;
                wb_do_q  <= wb_do_calc;
            end
            if (state_q == ST_XFER && mem.mem_ready) begin
                list_q <= list_q & ~(16'd1 << scan_idx);
                addr_q <= addr_q + 32'd4;
            end
        end
    end

    // Next state and outputs; everything is quiet outside the active states
    always_comb begin
        state_d       = state_q;
        busy          = 1'b0;
        done          = 1'b0;
        reg_addr      = 4'd0;
        latch_reg     = 1'b0;
        wb_data       = 32'd0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = 32'd0;
        mem.mem_wdata = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CALC;
            end
            ST_CALC: begin
                busy    = 1'b1;
                state_d = (scan_cnt == 5'd0) ? ST_DONE : ST_XFER;
            end
            ST_XFER: begin
                busy         = 1'b1;
                mem.mem_req  = 1'b1;
                mem.mem_we   = !load_q;
                mem.mem_addr = addr_q;
                reg_addr     = scan_idx;
                if (!load_q) mem.mem_wdata = store_data;
                if (mem.mem_ready) begin
                    if (load_q) begin
                        latch_reg = 1'b1;
                        wb_data   = mem.mem_rdata;
                    end
                    if (scan_cnt == 5'd1) state_d = wb_do_q ? ST_WB : ST_DONE;
                end
            end
            ST_WB: begin
                busy      = 1'b1;
                latch_reg = 1'b1;
                reg_addr  = rn_q;
                wb_data   = wb_val_q;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_block_xfer_seq.sv
// Purpose: scoreboard bench for block_xfer_seq with directed LDM/STM vectors.
// Latency: expected events carry their cycle offset from the accepted start.
// Backpressure: memory stalls injected via a per-test mem_ready window.
module tb_block_xfer_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] instr;
    logic [31:0] base_data;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [3:0]  reg_addr;
    logic        latch_reg;
    logic [31:0] wb_data;

    block_xfer_seq_if m ();

    block_xfer_seq #(.BASE_WB_EN(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .instr      (instr),
        .base_data  (base_data),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .reg_addr   (reg_addr),
        .latch_reg  (latch_reg),
        .wb_data    (wb_data),
        .mem        (m.master)
    );

    // Bench register bank and memory: simple data patterns keyed by index/address
    assign store_data  = 32'hA000_0000 | {28'd0, reg_addr};
    assign m.mem_rdata = 32'hD000_0000 ^ m.mem_addr;

    typedef struct {
        int          kind;   // 0 memory access, 1 bank write, 2 done
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  rg;
        logic        we;
        int          rel;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  start_cyc = 0;
    logic stall_en = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Memory readiness: low for cycles 3..5 after start when a stall is requested
    always @(posedge clk) begin
        #1;
        m.mem_ready = !(stall_en && (cyc - start_cyc) >= 3 && (cyc - start_cyc) <= 5);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic push_mem(input logic [31:0] a, input logic we, input logic [3:0] rg,
                            input logic [31:0] d, input int rel);
        ev_t e;
        e.kind = 0; e.addr = a; e.we = we; e.rg = rg; e.data = d; e.rel = rel;
        q.push_back(e);
    endtask

    task automatic push_bank(input logic [3:0] rg, input logic [31:0] d, input int rel);
        ev_t e;
        e.kind = 1; e.addr = 32'd0; e.we = 1'b0; e.rg = rg; e.data = d; e.rel = rel;
        q.push_back(e);
    endtask

    task automatic push_done(input int rel);
        ev_t e;
        e.kind = 2; e.addr = 32'd0; e.we = 1'b0; e.rg = 4'd0; e.data = 32'd0; e.rel = rel;
        q.push_back(e);
    endtask

    task automatic take(input int kind, input int rel);
        ev_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d at rel %0d, expected none", kind, rel);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", rel, e.rel);
            if (e.kind == 0 && kind == 0) begin
                chk("mem_addr", m.mem_addr, e.addr);
                chk("mem_we", {31'd0, m.mem_we}, {31'd0, e.we});
                chk("mem_reg", {28'd0, reg_addr}, {28'd0, e.rg});
                if (e.we) chk("mem_wdata", m.mem_wdata, e.data);
            end else if (e.kind == 1 && kind == 1) begin
                chk("bank_reg", {28'd0, reg_addr}, {28'd0, e.rg});
                chk("bank_data", wb_data, e.data);
            end else if (e.kind == 2 && kind == 2) begin
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    endtask

    // Monitor: compare DUT activity against the expected-event queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (m.mem_req && !m.mem_ready && q.size() > 0 && q[0].kind == 0) begin
                chk("stall_addr", m.mem_addr, q[0].addr);
                chk("stall_reg", {28'd0, reg_addr}, {28'd0, q[0].rg});
            end
            if (m.mem_req && m.mem_ready) take(0, cyc - start_cyc);
            if (latch_reg)                take(1, cyc - start_cyc);
            if (done)                     take(2, cyc - start_cyc);
        end
    end

    task automatic do_start(input logic [31:0] ins, input logic [31:0] base);
        @(posedge clk); #1;
        start = 1'b1; instr = ins; base_data = base; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0; instr = 32'd0; base_data = 32'd0;
        chk("busy_in_calc", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d events outstanding, expected 0", name, q.size());
            q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic check_quiet(input string name);
        chk({name, "_busy"},  {31'd0, busy},      32'd0);
        chk({name, "_done"},  {31'd0, done},      32'd0);
        chk({name, "_latch"}, {31'd0, latch_reg}, 32'd0);
        chk({name, "_req"},   {31'd0, m.mem_req}, 32'd0);
        chk({name, "_we"},    {31'd0, m.mem_we},  32'd0);
        chk({name, "_raddr"}, {28'd0, reg_addr},  32'd0);
        chk({name, "_maddr"}, m.mem_addr,         32'd0);
        chk({name, "_wbd"},   wb_data,            32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; instr = 32'd0; base_data = 32'd0;
        #1;
        check_quiet("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // LDMIA R0!,{R1,R2,R4}, plus an ignored start while busy
        push_mem(32'h1000, 1'b0, 4'd1, 32'd0, 2); push_bank(4'd1, 32'hD000_1000, 2);
        push_mem(32'h1004, 1'b0, 4'd2, 32'd0, 3); push_bank(4'd2, 32'hD000_1004, 3);
        push_mem(32'h1008, 1'b0, 4'd4, 32'd0, 4); push_bank(4'd4, 32'hD000_1008, 4);
        push_bank(4'd0, 32'h0000_100C, 5);
        push_done(6);
        do_start(32'hE8B0_0016, 32'h1000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; instr = 32'hE8B0_0000;
        @(posedge clk); #1;
        start = 1'b0; instr = 32'd0;
        wait_empty("ldmia");

        // STMDB R13!,{R0,R14}
        push_mem(32'h1FF8, 1'b1, 4'd0,  32'hA000_0000, 2);
        push_mem(32'h1FFC, 1'b1, 4'd14, 32'hA000_000E, 3);
        push_bank(4'd13, 32'h0000_1FF8, 4);
        push_done(5);
        do_start(32'hE92D_4001, 32'h2000);
        wait_empty("stmdb");

        // LDMIA R0!,{R0,R1}: base in list, loaded value wins
        push_mem(32'h0100, 1'b0, 4'd0, 32'd0, 2); push_bank(4'd0, 32'hD000_0100, 2);
        push_mem(32'h0104, 1'b0, 4'd1, 32'd0, 3); push_bank(4'd1, 32'hD000_0104, 3);
        push_done(4);
        do_start(32'hE8B0_0003, 32'h0100);
        wait_empty("ldm_rn_in_list");

        // LDMIA R5,{R1,R2} with memory stalled on the second access
        stall_en = 1'b1;
        push_mem(32'h3000, 1'b0, 4'd1, 32'd0, 2); push_bank(4'd1, 32'hD000_3000, 2);
        push_mem(32'h3004, 1'b0, 4'd2, 32'd0, 6); push_bank(4'd2, 32'hD000_3004, 6);
        push_done(7);
        do_start(32'hE895_0006, 32'h3000);
        wait_empty("stall");
        stall_en = 1'b0;

        // Empty list
        push_done(2);
        do_start(32'hE8B0_0000, 32'h1000);
        wait_empty("empty");

        // STMIB R2!,{R3}
        push_mem(32'h0044, 1'b1, 4'd3, 32'hA000_0003, 2);
        push_bank(4'd2, 32'h0000_0044, 3);
        push_done(4);
        do_start(32'hE9A2_0008, 32'h0040);
        wait_empty("stmib");

        // LDMDA R7,{R1,R3}
        push_mem(32'h04FC, 1'b0, 4'd1, 32'd0, 2); push_bank(4'd1, 32'hD000_04FC, 2);
        push_mem(32'h0500, 1'b0, 4'd3, 32'd0, 3); push_bank(4'd3, 32'hD000_0500, 3);
        push_done(4);
        do_start(32'hE817_000A, 32'h0500);
        wait_empty("ldmda");

        // Reset during the second transfer aborts the operation
        push_mem(32'h1000, 1'b0, 4'd1, 32'd0, 2); push_bank(4'd1, 32'hD000_1000, 2);
        do_start(32'hE8B0_0016, 32'h1000);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_quiet("abort");
        chk("abort_queue", q.size(), 32'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Normal operation after abort
        push_mem(32'h1FF8, 1'b1, 4'd0,  32'hA000_0000, 2);
        push_mem(32'h1FFC, 1'b1, 4'd14, 32'hA000_000E, 3);
        push_bank(4'd13, 32'h0000_1FF8, 4);
        push_done(5);
        do_start(32'hE92D_4001, 32'h2000);
        wait_empty("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global guard against a hung run
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
